// File: rtl/eth_tx_sched_if.sv
// Handshake bundle between the trace/control frame sources, the MAC and the scheduler.
// The scheduler uses the slave modport; the source/MAC side uses the master modport.
interface eth_tx_sched_if;
  logic [1:0]  SrcValid;
  logic [1:0]  SrcLast;
  logic [1:0]  SrcReady;
  logic        TxValid;
  logic        TxLast;
  logic        TxReady;
  logic        TxSel;
  logic        HostStall;
  logic        RVVIStall;
  logic [31:0] TraceFrameCount;
  logic [31:0] CtrlFrameCount;

  modport master (
    output SrcValid, SrcLast, TxReady, HostStall,
    input  SrcReady, TxValid, TxLast, TxSel, RVVIStall, TraceFrameCount, CtrlFrameCount
  );

  modport slave (
    input  SrcValid, SrcLast, TxReady, HostStall,
    output SrcReady, TxValid, TxLast, TxSel, RVVIStall, TraceFrameCount, CtrlFrameCount
  );
endinterface

// File: rtl/eth_tx_sched.sv
// Two-source Ethernet TX frame scheduler: control wins unless trace is starved; 1-cycle grant, IFG gap after each frame.
// Beats pass combinationally under MAC TxReady; frame counters only exist when TXSCHED_STATS_EN is defined.
module eth_tx_sched #(
  parameter int IFG_CYCLES   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         resetn,
  eth_tx_sched_if.slave bus
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD   = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              tx_sel_q, tx_sel_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ST_W-1:0]   starve_q, starve_d;

  logic              in_tx;
  logic              sel_valid;
  logic              sel_last;
  logic              tx_valid;
  logic              tx_last;
  logic [1:0]        src_ready;
  logic              frame_done;
  logic              forced_trace;

  always_comb begin
    state_d   = state_q;
    tx_sel_d  = tx_sel_q;
    gap_d     = gap_q;
    starve_d  = starve_q;

    // Outputs are gated by resetn so nothing leaks out while reset is held.
    in_tx     = resetn && (state_q == ST_TX);
    sel_valid = bus.SrcValid[tx_sel_q];
    sel_last  = bus.SrcLast[tx_sel_q];
    tx_valid  = in_tx & sel_valid;
    tx_last   = in_tx & sel_last;
    src_ready = 2'b00;
    if (in_tx) begin
      src_ready[tx_sel_q] = bus.TxReady;
    end
    frame_done   = tx_valid & bus.TxReady & sel_last;
    forced_trace = (starve_q == STARVE_MAX) && bus.SrcValid[0] && !bus.HostStall;

    case (state_q)
      ST_IDLE: begin
        if (bus.SrcValid[1] && !forced_trace) begin
          tx_sel_d = 1'b1;
          state_d  = ST_TX;
        end else if (bus.SrcValid[0] && !bus.HostStall) begin
          tx_sel_d = 1'b0;
          state_d  = ST_TX;
        end
      end
      ST_TX: begin
        if (frame_done) begin
          if (IFG_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
          // Only control frames that overtook a waiting trace frame count toward starvation.
          if (tx_sel_q) begin
            if (bus.SrcValid[0] && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            starve_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      tx_sel_q <= 1'b0;
      gap_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_sel_q <= tx_sel_d;
      gap_q    <= gap_d;
      starve_q <= starve_d;
    end
  end

  assign bus.TxValid   = tx_valid;
  assign bus.TxLast    = tx_last;
  assign bus.SrcReady  = src_ready;
  assign bus.TxSel     = tx_sel_q;
  assign bus.RVVIStall = bus.HostStall |
                         (bus.SrcValid[0] & ~((state_q == ST_TX) & ~tx_sel_q));

`ifdef TXSCHED_STATS_EN
  logic [31:0] trace_cnt_q, trace_cnt_d;
  logic [31:0] ctrl_cnt_q, ctrl_cnt_d;

  always_comb begin
    trace_cnt_d = trace_cnt_q;
    ctrl_cnt_d  = ctrl_cnt_q;
    if (frame_done) begin
      if (tx_sel_q) begin
        ctrl_cnt_d = ctrl_cnt_q + 32'd1;
      end else begin
        trace_cnt_d = trace_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      trace_cnt_q <= '0;
      ctrl_cnt_q  <= '0;
    end else begin
      trace_cnt_q <= trace_cnt_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
    end
  end

  assign bus.TraceFrameCount = trace_cnt_q;
  assign bus.CtrlFrameCount  = ctrl_cnt_q;
`else
  assign bus.TraceFrameCount = 32'd0;
  assign bus.CtrlFrameCount  = 32'd0;
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: frames are queued per source with tagged beats,
// and every MAC-side beat is popped from the expected queue of the selected source.
module tb_eth_tx_sched;
  localparam int IFG    = 12;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  eth_tx_sched_if bus();

  eth_tx_sched #(.IFG_CYCLES(IFG), .STARVE_LIMIT(STARVE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [15:0] dat;
    logic        last;
  } beat_t;

  beat_t src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
  logic  order_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fires0 = 0, fires1 = 0;
  int model_trace = 0, model_ctrl = 0;
  logic [15:0] next_tag = 16'h0100;
  logic [15:0] dat0, dat1;
  logic host_stall = 1'b0;
  logic tx_ready = 1'b1;
  logic mon_txv, mon_sel, mon_rvvi, mon_fire, mon_last;
  logic [1:0] mon_srdy;

  function automatic int exp_cnt(input int m);
`ifdef TXSCHED_STATS_EN
    return m;
`else
    return 0;
`endif
  endfunction

  task automatic push_frame(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.dat = next_tag;
      b.last = (i == n - 1);
      next_tag = next_tag + 16'd1;
      if (s == 0) begin
        src_q0.push_back(b);
        exp_q0.push_back(b);
      end else begin
        src_q1.push_back(b);
        exp_q1.push_back(b);
      end
    end
  endtask

  // One clock cycle: drive sources from their queues, sample mid-cycle, score MAC beats.
  task automatic tick();
    beat_t e;
    logic [1:0] hs;
    logic [15:0] mux;
    bus.SrcValid[0] = (src_q0.size() > 0);
    bus.SrcLast[0]  = (src_q0.size() > 0) ? src_q0[0].last : 1'b0;
    dat0            = (src_q0.size() > 0) ? src_q0[0].dat : 16'h0;
    bus.SrcValid[1] = (src_q1.size() > 0);
    bus.SrcLast[1]  = (src_q1.size() > 0) ? src_q1[0].last : 1'b0;
    dat1            = (src_q1.size() > 0) ? src_q1[0].dat : 16'h0;
    bus.HostStall   = host_stall;
    bus.TxReady     = tx_ready;
    #1;
    mon_txv  = bus.TxValid;
    mon_sel  = bus.TxSel;
    mon_rvvi = bus.RVVIStall;
    mon_srdy = bus.SrcReady;
    mon_last = bus.TxLast;
    mon_fire = bus.TxValid & bus.TxReady;
    if (mon_fire) begin
      mux = bus.TxSel ? dat1 : dat0;
      checks++;
      if (!bus.TxSel) begin
        if (exp_q0.size() == 0) begin
          errors++;
          $display("FAIL sb_trace_unexpected got dat=%h last=%b, expected no beat", mux, mon_last);
        end else begin
          e = exp_q0.pop_front();
          if ({mux, mon_last} !== {e.dat, e.last}) begin
            errors++;
            $display("FAIL sb_trace_beat got dat=%h last=%b expected dat=%h last=%b", mux, mon_last, e.dat, e.last);
          end
        end
        fires0++;
        if (mon_last) model_trace++;
      end else begin
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL sb_ctrl_unexpected got dat=%h last=%b, expected no beat", mux, mon_last);
        end else begin
          e = exp_q1.pop_front();
          if ({mux, mon_last} !== {e.dat, e.last}) begin
            errors++;
            $display("FAIL sb_ctrl_beat got dat=%h last=%b expected dat=%h last=%b", mux, mon_last, e.dat, e.last);
          end
        end
        fires1++;
        if (mon_last) model_ctrl++;
      end
      if (mon_last) order_q.push_back(bus.TxSel);
    end
    hs = bus.SrcValid & bus.SrcReady;
    @(posedge clk);
    if (hs[0]) src_q0.delete(0);
    if (hs[1]) src_q1.delete(0);
    cyc++;
    #1;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 500; i++) begin
      if (src_q0.size() == 0 && src_q1.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0) break;
      tick();
    end
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d/%0d beats pending, expected 0/0", name, exp_q0.size(), exp_q1.size());
    end
    repeat (IFG + 2) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    host_stall = 1'b1;
    tick();
    checks++;
    if (mon_rvvi !== 1'b1) begin
      errors++; $display("FAIL reset_rvvi_stall got %b expected 1", mon_rvvi);
    end
    host_stall = 1'b0;
    tick();
    checks++;
    if ({mon_rvvi, mon_txv, mon_last, mon_srdy} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got rvvi/txv/last/srdy=%b%b%b%b expected 00000", mon_rvvi, mon_txv, mon_last, mon_srdy);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if ({mon_txv, mon_sel, mon_srdy} !== 4'b0) begin
      errors++; $display("FAIL post_reset_idle got txv/sel/srdy=%b%b%b expected 0000", mon_txv, mon_sel, mon_srdy);
    end
    checks++;
    if (bus.TraceFrameCount !== 32'd0 || bus.CtrlFrameCount !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", bus.TraceFrameCount, bus.CtrlFrameCount);
    end
  endtask

  task automatic test_single_trace();
    int c0, first, lastc, n, low;
    first = -1; lastc = -1; n = 0; low = 0;
    push_frame(0, 3);
    c0 = cyc;
    for (int i = 0; i < 20 && lastc < 0; i++) begin
      int c;
      c = cyc;
      tick();
      if (mon_fire) begin
        if (first < 0) first = c;
        n++;
        if (mon_last) lastc = c;
      end
    end
    checks++;
    if (first != c0 + 1 || lastc != c0 + 3 || n != 3) begin
      errors++; $display("FAIL trace_timing got first=%0d last=%0d beats=%0d expected %0d/%0d/3", first, lastc, n, c0 + 1, c0 + 3);
    end
    checks++;
    if (bus.TraceFrameCount !== 32'(exp_cnt(1))) begin
      errors++; $display("FAIL trace_count got %0d expected %0d", bus.TraceFrameCount, exp_cnt(1));
    end
    // Back-to-back trace frame: gap cycles plus the one-cycle arbitration in IDLE.
    push_frame(0, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mon_txv) break;
      low++;
    end
    checks++;
    if (low != IFG + 1) begin
      errors++; $display("FAIL ifg_gap got %0d idle cycles expected %0d", low, IFG + 1);
    end
    drain("single_trace");
  endtask

  task automatic test_ctrl_priority();
    push_frame(0, 2);
    push_frame(1, 3);
    tick();
    checks++;
    if ({mon_txv, mon_rvvi} !== 2'b01) begin
      errors++; $display("FAIL prio_idle got txv/rvvi=%b%b expected 01", mon_txv, mon_rvvi);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({mon_txv, mon_sel, mon_rvvi} !== 3'b111) begin
        errors++; $display("FAIL prio_ctrl_frame got txv/sel/rvvi=%b%b%b expected 111", mon_txv, mon_sel, mon_rvvi);
      end
      if (mon_fire && mon_last) break;
    end
    drain("ctrl_priority");
  endtask

  task automatic test_starvation();
    logic [11:0] exp_order;
    exp_order = 12'b1111_0111_1011;
    order_q.delete();
    for (int i = 0; i < 10; i++) push_frame(1, 1);
    push_frame(0, 1);
    push_frame(0, 1);
    drain("starvation");
    checks++;
    if (order_q.size() != 12) begin
      errors++; $display("FAIL starve_frame_total got %0d expected 12", order_q.size());
    end
    for (int i = 0; i < 12 && i < order_q.size(); i++) begin
      checks++;
      if (order_q[i] !== exp_order[11 - i]) begin
        errors++; $display("FAIL starve_order frame %0d got sel=%b expected %b", i, order_q[i], exp_order[11 - i]);
      end
    end
  endtask

  task automatic test_host_stall();
    int f, rvvi_low;
    rvvi_low = 0;
    host_stall = 1'b1;
    push_frame(0, 5);
    repeat (5) begin
      tick();
      checks++;
      if ({mon_txv, mon_rvvi} !== 2'b01) begin
        errors++; $display("FAIL stall_blocks_grant got txv/rvvi=%b%b expected 01", mon_txv, mon_rvvi);
      end
    end
    host_stall = 1'b0;
    f = fires0;
    for (int i = 0; i < 10 && (fires0 - f) < 2; i++) tick();
    checks++;
    if (fires0 - f != 2) begin
      errors++; $display("FAIL stall_start_beats got %0d expected 2", fires0 - f);
    end
    host_stall = 1'b1;
    push_frame(0, 2);
    f = fires0;
    repeat (40) begin
      tick();
      if (mon_rvvi !== 1'b1) rvvi_low++;
    end
    checks++;
    if (fires0 - f != 3 || exp_q0.size() != 2) begin
      errors++; $display("FAIL stall_midframe got beats=%0d pending=%0d expected 3/2", fires0 - f, exp_q0.size());
    end
    checks++;
    if (rvvi_low != 0) begin
      errors++; $display("FAIL stall_rvvi got %0d low cycles expected 0", rvvi_low);
    end
    host_stall = 1'b0;
    drain("host_stall");
  endtask

  task automatic test_backpressure();
    int f;
    tx_ready = 1'b1;
    f = fires1;
    push_frame(1, 2);
    for (int i = 0; i < 10 && fires1 == f; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tx_ready = (i == 2);
      tick();
      checks++;
      if ({mon_txv, mon_sel, mon_srdy} !== {1'b1, 1'b1, tx_ready, 1'b0}) begin
        errors++; $display("FAIL bp_cycle%0d got txv/sel/srdy=%b%b%b expected 11%b0", i, mon_txv, mon_sel, mon_srdy, tx_ready);
      end
    end
    checks++;
    if (fires1 - f != 2) begin
      errors++; $display("FAIL bp_beats got %0d expected 2", fires1 - f);
    end
    tx_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_counters();
    checks++;
    if (bus.TraceFrameCount !== 32'(exp_cnt(model_trace)) || bus.CtrlFrameCount !== 32'(exp_cnt(model_ctrl))) begin
      errors++; $display("FAIL frame_counters got %0d/%0d expected %0d/%0d", bus.TraceFrameCount, bus.CtrlFrameCount, exp_cnt(model_trace), exp_cnt(model_ctrl));
    end
  endtask

  task automatic test_reset_mid();
    int f;
    f = fires0;
    push_frame(0, 4);
    for (int i = 0; i < 10 && fires0 == f; i++) tick();
    resetn = 1'b0;
    tick();
    checks++;
    if ({mon_txv, mon_srdy} !== 3'b000) begin
      errors++; $display("FAIL midreset_outputs got txv/srdy=%b%b expected 000", mon_txv, mon_srdy);
    end
    // The truncated frame is abandoned by the source and restarted from scratch.
    src_q0.delete();
    exp_q0.delete();
    model_trace = 0;
    model_ctrl = 0;
    resetn = 1'b1;
    tick();
    checks++;
    if ({mon_txv, mon_sel} !== 2'b00) begin
      errors++; $display("FAIL midreset_idle got txv/sel=%b%b expected 00", mon_txv, mon_sel);
    end
    checks++;
    if (bus.TraceFrameCount !== 32'd0 || bus.CtrlFrameCount !== 32'd0) begin
      errors++; $display("FAIL midreset_counters got %0d/%0d expected 0/0", bus.TraceFrameCount, bus.CtrlFrameCount);
    end
    push_frame(0, 4);
    drain("reset_restart");
    checks++;
    if (bus.TraceFrameCount !== 32'(exp_cnt(1))) begin
      errors++; $display("FAIL restart_count got %0d expected %0d", bus.TraceFrameCount, exp_cnt(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    test_reset();
    test_single_trace();
    test_ctrl_priority();
    test_starvation();
    test_host_stall();
    test_backpressure();
    test_counters();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle gap cycles inserted after each frame (0 = no gap).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive control frames allowed while trace waits before trace is forced.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 SrcValid  in  2  beat valid per source; bit0 = trace frame source, bit1 = control (slow-down ack) frame source.
REQ-006 SrcLast  in  2  last beat of frame, per source, qualified by SrcValid.
REQ-007 SrcReady  out  2  beat accepted, per source.
REQ-008 TxValid  out  1  beat valid to Ethernet MAC.
REQ-009 TxLast  out  1  last beat to MAC.
REQ-010 TxReady  in  1  MAC accepts beat.
REQ-011 TxSel  out  1  data-mux select for the external data path: 0 = trace, 1 = control.
REQ-012 HostStall  in  1  host slow-down in effect; blocks new trace grants.
REQ-013 RVVIStall  out  1  stall to trace producer.
REQ-014 TraceFrameCount, CtrlFrameCount  out  32 each  completed-frame counters (see Configuration).

Function
REQ-015 States SHALL be IDLE, TX, GAP.
REQ-016 IDLE: if SrcValid[1] and not forced-trace, grant control; else if SrcValid[0] and HostStall=0, grant trace; else stay IDLE.
REQ-017 Forced-trace SHALL hold when the starvation counter equals STARVE_LIMIT and SrcValid[0]=1 and HostStall=0; trace is then granted even if SrcValid[1]=1.
REQ-018 Grant SHALL load TxSel and move to TX on the next edge; no beat is transferred in IDLE (one-cycle arbitration latency).
REQ-019 TX: TxValid=SrcValid[TxSel], TxLast=SrcLast[TxSel], SrcReady[TxSel]=TxReady, SrcReady[~TxSel]=0; TxSel SHALL not change in TX.
REQ-020 TX exit: on TxValid&TxReady&TxLast go to GAP, or to IDLE directly when IFG_CYCLES=0.
REQ-021 GAP: down-counter loaded with IFG_CYCLES-1 on entry; return to IDLE when it reads 0; TxValid=0, SrcReady=0 in GAP and IDLE.
REQ-022 HostStall asserted during TX SHALL NOT abort or pause the frame in progress.
REQ-023 Starvation counter (width ceil(log2(STARVE_LIMIT+1))): increments on control frame completion while SrcValid[0]=1, saturates at STARVE_LIMIT; clears on trace frame completion.
REQ-024 RVVIStall = HostStall | (SrcValid[0] & ~(state==TX & TxSel==0)), combinational.
REQ-025 Frame counters increment by 1 on last-beat handshake of the respective source; wrap 0xFFFFFFFF -> 0.

Reset
REQ-026 resetn=0 at a rising edge SHALL force IDLE, TxSel=0, GAP counter=0, starvation counter=0, frame counters=0, regardless of frame in progress.
REQ-027 During and after reset: TxValid=0, TxLast=0, SrcReady=0; RVVIStall follows REQ-024.
REQ-028 A frame truncated by reset SHALL not be counted; the source must restart it.

Configuration
REQ-029 Macro TXSCHED_STATS_EN: defined -> frame counters implemented per REQ-025; undefined -> counter flops omitted, TraceFrameCount and CtrlFrameCount tied to 0; all other behaviour identical.

Verification
REQ-030 Single trace frame of 3 beats, TxReady=1, IFG_CYCLES=12 -> grant 1 cycle after SrcValid[0], beats in 3 consecutive cycles, TxValid low exactly 12 cycles, then IDLE; TraceFrameCount=1.
REQ-031 Both sources valid in IDLE -> control granted (TxSel=1); trace waits, RVVIStall=1 throughout control frame.
REQ-032 Control continuously valid with trace valid, STARVE_LIMIT=4 -> 4 control frames, then 1 trace frame, then control; starvation counter returns to 0.
REQ-033 HostStall=1, only trace valid -> stays IDLE, RVVIStall=1; HostStall raised mid-trace-frame of 5 beats -> all 5 beats sent, no new trace grant afterward.
REQ-034 TxReady toggled 1,0,0,1 during 2-beat control frame -> SrcReady[1] mirrors TxReady, no beat lost or duplicated, TxSel stable.
REQ-035 resetn=0 on beat 2 of 4 -> next cycle IDLE, TxValid=0, counters 0; with TXSCHED_STATS_EN undefined counters read 0 after any traffic.
